// File: rtl/key_conditioner_pkg.sv
// Shared constants and types for the key conditioning front end.
package key_conditioner_pkg;

    // System clock frequency of the board.
    localparam int CLK_HZ = 50_000_000;

    // Convert a duration in milliseconds to a count of CLK_HZ cycles.
    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    // Auto-repeat state of one key channel.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RATE  = 2'd2
    } rpt_state_e;

endpackage

// File: rtl/key_conditioner_channel.sv
// One key channel: 2-flop synchroniser, counter debounce, press/release
// pulse generation and an optional auto-repeat FSM for held keys.
module key_conditioner_channel
    import key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_n_i,
    output logic level_o,
    output logic level_next_o,
    output logic press_o,
    output logic release_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject parameter sets the counters cannot represent.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("key_conditioner_channel: illegal timing parameters");
    end

    logic [1:0]       sync_q;
    logic             s_key;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             rise_d;
    logic             fall_d;
    logic             edge_press_q;
    logic             release_q;
    logic             rpt_pulse;

    // Synchroniser holds the raw active-low key; reset value 1 means released.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_n_i};
        end
    end

    assign s_key = ~sync_q[1];

    // Count consecutive samples that disagree with the accepted level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (s_key != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = s_key;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign rise_d = level_d & ~level_q;
    assign fall_d = level_q & ~level_d;

    // Debounced level plus registered edge pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q      <= 1'b0;
            cnt_q        <= '0;
            edge_press_q <= 1'b0;
            release_q    <= 1'b0;
        end else begin
            level_q      <= level_d;
            cnt_q        <= cnt_d;
            edge_press_q <= rise_d;
            release_q    <= fall_d;
        end
    end

    if (REPEAT_EN != 0) begin : g_repeat
        localparam int TMR_SPAN = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
        localparam int TMR_W    = (TMR_SPAN > 2) ? $clog2(TMR_SPAN) : 1;
        localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
        localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE - 1);

        rpt_state_e       state_q;
        logic [TMR_W-1:0] timer_q;
        logic             rpt_q;

        // Auto-repeat: initial delay after the accepted press, then a fixed
        // rate; a falling level cancels immediately without a final pulse.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= IDLE;
                timer_q <= '0;
                rpt_q   <= 1'b0;
            end else begin
                rpt_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        if (rise_d) begin
                            state_q <= DELAY;
                            timer_q <= '0;
                        end
                    end
                    DELAY: begin
                        if (fall_d) begin
                            state_q <= IDLE;
                        end else if (timer_q == DELAY_LAST) begin
                            rpt_q   <= 1'b1;
                            state_q <= RATE;
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    RATE: begin
                        if (fall_d) begin
                            state_q <= IDLE;
                        end else if (timer_q == RATE_LAST) begin
                            rpt_q   <= 1'b1;
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        timer_q <= '0;
                    end
                endcase
            end
        end

        assign rpt_pulse = rpt_q;
    end else begin : g_no_repeat
        assign rpt_pulse = 1'b0;
    end

    assign level_o      = level_q;
    assign level_next_o = level_d;
    assign press_o      = edge_press_q | rpt_pulse;
    assign release_o    = release_q;

endmodule

// File: rtl/key_conditioner.sv
// N-channel push-button conditioner: turns raw active-low board keys into
// clean debounced levels and one-cycle press/release events.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int N_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic [N_KEYS-1:0] KEY_N,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic              any_pressed
);

    logic [N_KEYS-1:0] level_next;
    logic              any_pressed_q;

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
        key_conditioner_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
        ) u_chan (
            .clk_i        (CLOCK_50),
            .rst_ni       (resetn),
            .key_n_i      (KEY_N[gi]),
            .level_o      (key_level[gi]),
            .level_next_o (level_next[gi]),
            .press_o      (press_pulse[gi]),
            .release_o    (release_pulse[gi])
        );
    end

    // OR of the next-state levels so any_pressed lines up with key_level.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            any_pressed_q <= 1'b0;
        end else begin
            any_pressed_q <= |level_next;
        end
    end

    assign any_pressed = any_pressed_q;

endmodule
